// File: rtl/t03_decode_queue_if.sv
// t03_decode_queue_if: fetch-side push and execute-side pop bundle for t03_decode_queue.
// The queue itself takes the slave modport; the fetch/execute side takes master.
interface t03_decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_inst;
    logic [XLEN-1:0]        in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [4:0]             out_rs1;
    logic [4:0]             out_rs2;
    logic [4:0]             out_rd;
    logic [2:0]             out_type;
    logic [16:0]            out_control;
    logic [XLEN-1:0]        out_imm;
    logic                   out_illegal;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_type, out_control, out_imm, out_illegal, count
    );
    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_type, out_control, out_imm, out_illegal, count
    );
endinterface

// File: rtl/t03_decode_queue.sv
// t03_decode_queue: RV-style instruction decoder feeding a circular FIFO of decoded records.
// Define T03_DECODE_ILLEGAL_EN to flag and blank illegal encodings instead of decoding them as R.
module t03_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              nRst,
    t03_decode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3, T_UJ = 3'd4, T_U = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [16:0]     ctl;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      typ;
        logic            ill;
    } rec_t;

    logic [31:0] inst;
    logic [6:0]  opc;
    logic        is_r, is_i, is_s, is_sb, is_uj, is_u, known, bad;
    rec_t        dec_d;

    assign inst  = bus.in_inst;
    assign opc   = inst[6:0];
    assign is_i  = opc inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0001111};
    assign is_r  = opc inside {7'b0110011, 7'b0111011};
    assign is_s  = opc == 7'b0100011;
    assign is_sb = opc == 7'b1100011;
    assign is_uj = opc == 7'b1101111;
    assign is_u  = opc inside {7'b0110111, 7'b0010111};
    assign known = is_r | is_i | is_s | is_sb | is_uj | is_u;

`ifdef T03_DECODE_ILLEGAL_EN
    assign bad = (inst[1:0] != 2'b11) | ~known | (is_r & ~(inst[31:25] inside {7'h00, 7'h20}));
`else
    assign bad = 1'b0;
`endif

    // Unrecognised opcodes fall through every is_* test and so decode with the R field set.
    always_comb begin
        dec_d     = '0;
        dec_d.pc  = bus.in_pc;
        dec_d.ill = bad;
        if (!bad) begin
            dec_d.typ = is_i ? T_I : is_s ? T_S : is_sb ? T_SB : is_uj ? T_UJ : is_u ? T_U : T_R;
            dec_d.rs1 = (is_u | is_uj) ? 5'd0 : inst[19:15];
            dec_d.rs2 = (is_i | is_u | is_uj) ? 5'd0 : inst[24:20];
            dec_d.rd  = (is_s | is_sb) ? 5'd0 : inst[11:7];
            dec_d.ctl = {(is_i | is_s | is_sb | is_u | is_uj) ? 7'd0 : inst[31:25],
                         (is_u | is_uj) ? 3'd0 : inst[14:12], opc};
            dec_d.imm = is_i  ? XLEN'($signed(inst[31:20]))
                      : is_s  ? XLEN'($signed({inst[31:25], inst[11:7]}))
                      : is_sb ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}))
                      : is_u  ? XLEN'($signed({inst[31:12], 12'b0}))
                      : is_uj ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}))
                      : '0;
        end
    end

    rec_t          mem_q [DEPTH];
    rec_t          hd;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign bus.in_ready  = cnt_q < CW'(DEPTH);
    assign bus.out_valid = cnt_q != '0;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_d  = bus.flush ? '0 : wr_q + PW'(push);
        rd_d  = bus.flush ? '0 : rd_q + PW'(pop);
        cnt_d = bus.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem_q[wr_q] <= dec_d;
    end

    assign hd              = bus.out_valid ? mem_q[rd_q] : '0;
    assign bus.out_pc      = hd.pc;
    assign bus.out_rs1     = hd.rs1;
    assign bus.out_rs2     = hd.rs2;
    assign bus.out_rd      = hd.rd;
    assign bus.out_type    = hd.typ;
    assign bus.out_control = hd.ctl;
    assign bus.out_imm     = hd.imm;
    assign bus.out_illegal = hd.ill;
    assign bus.count       = cnt_q;
endmodule

// File: tb/tb_t03_decode_queue.sv
// tb_t03_decode_queue: directed and random checks of the decode queue against a queue-based reference.
module tb_t03_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef T03_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nRst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    t03_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();
    t03_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .nRst(nRst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      typ;
        logic [4:0]      rs1, rs2, rd;
        logic [16:0]     ctl;
        logic [XLEN-1:0] imm;
        logic            ill;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t q[$];

    function automatic exp_t zrec(input logic [XLEN-1:0] pc);
        exp_t e;
        e.typ = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctl = '0; e.imm = '0; e.ill = 1'b0; e.pc = pc;
        return e;
    endfunction

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic signed [63:0] s;
        s = $signed(v << (64 - bits));
        return 64'(s >>> (64 - bits));
    endfunction

    // Reference decode: type from the opcode table, then fields kept or zeroed by type.
    function automatic exp_t model_dec(input logic [31:0] i, input logic [XLEN-1:0] pc);
        exp_t e;
        int t;
        bit known;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [63:0] imm;
        e = zrec(pc);
        known = 1'b1;
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: t = 1;
            7'h33, 7'h3B: t = 0;
            7'h23: t = 2;
            7'h63: t = 3;
            7'h6F: t = 4;
            7'h37, 7'h17: t = 5;
            default: begin t = 0; known = 1'b0; end
        endcase
        e.ill = ILL_EN && (i[1:0] != 2'b11 || !known || (t == 0 && i[31:25] != 7'h00 && i[31:25] != 7'h20));
        if (e.ill) return e;
        e.typ = 3'(t);
        e.rs1 = (t == 4 || t == 5) ? 5'd0 : i[19:15];
        e.rs2 = (t == 0 || t == 2 || t == 3) ? i[24:20] : 5'd0;
        e.rd  = (t == 0 || t == 1 || t == 4 || t == 5) ? i[11:7] : 5'd0;
        f3 = (t <= 3) ? i[14:12] : 3'd0;
        f7 = (t == 0) ? i[31:25] : 7'd0;
        e.ctl = {f7, f3, i[6:0]};
        case (t)
            1: imm = sx(64'(i[31:20]), 12);
            2: imm = sx(64'({i[31:25], i[11:7]}), 12);
            3: imm = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            4: imm = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            5: imm = sx(64'({i[31:12], 12'h000}), 32);
            default: imm = 64'd0;
        endcase
        e.imm = XLEN'(imm);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t h;
        h = (q.size() != 0) ? q[0] : zrec('0);
        chk({tag, ":count"},     64'(bus.count),       64'(q.size()));
        chk({tag, ":in_ready"},  64'(bus.in_ready),    64'(q.size() < DEPTH));
        chk({tag, ":out_valid"}, 64'(bus.out_valid),   64'(q.size() != 0));
        chk({tag, ":pc"},        64'(bus.out_pc),      64'(h.pc));
        chk({tag, ":rs1"},       64'(bus.out_rs1),     64'(h.rs1));
        chk({tag, ":rs2"},       64'(bus.out_rs2),     64'(h.rs2));
        chk({tag, ":rd"},        64'(bus.out_rd),      64'(h.rd));
        chk({tag, ":type"},      64'(bus.out_type),    64'(h.typ));
        chk({tag, ":control"},   64'(bus.out_control), 64'(h.ctl));
        chk({tag, ":imm"},       64'(bus.out_imm),     64'(h.imm));
        chk({tag, ":illegal"},   64'(bus.out_illegal), 64'(h.ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    // One clock: predict from pre-edge inputs, update the model at the edge, compare 1ns later.
    task automatic cyc(input string tag);
        bit push, pop;
        exp_t e;
        push = bus.in_valid && q.size() < DEPTH;
        pop  = q.size() != 0 && bus.out_ready;
        e    = model_dec(bus.in_inst, bus.in_pc);
        @(posedge clk);
        if (bus.flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1 check_all(tag);
    endtask

    logic [31:0]     fill_inst [5] = '{32'h002081B3, 32'h0020A023, 32'h123450B7, 32'h008000EF, 32'h0000A103};
    logic [6:0]      ops [13] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h33, 7'h3B,
                                  7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
    logic [XLEN-1:0] ones = '1;
    logic [XLEN-1:0] m4   = -4;

    initial begin
        logic [31:0] r;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        #1 nRst = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        #1 nRst = 1'b1;

        drive(1'b1, 32'hFFF10093, 'h100, 1'b0, 1'b0);
        cyc("addi");
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_type", 64'(bus.out_type), 64'd1);
        chk("addi_rs1", 64'(bus.out_rs1), 64'd2);
        chk("addi_rd", 64'(bus.out_rd), 64'd1);
        chk("addi_rs2", 64'(bus.out_rs2), 64'd0);
        chk("addi_imm", 64'(bus.out_imm), 64'(ones));
        chk("addi_ctl", 64'(bus.out_control), 64'(17'b0000000_000_0010011));

        drive(1'b1, 32'hFE208EE3, 'h104, 1'b1, 1'b0);
        cyc("beq");
        chk("beq_type", 64'(bus.out_type), 64'd3);
        chk("beq_rs1", 64'(bus.out_rs1), 64'd1);
        chk("beq_rs2", 64'(bus.out_rs2), 64'd2);
        chk("beq_rd", 64'(bus.out_rd), 64'd0);
        chk("beq_imm", 64'(bus.out_imm), 64'(m4));
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        cyc("beq_drain");

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, fill_inst[k], XLEN'('h200 + 4 * k), 1'b0, 1'b0);
            cyc($sformatf("fill%0d", k));
            if (k >= 3) begin
                chk($sformatf("full_ready%0d", k), 64'(bus.in_ready), 64'd0);
                chk($sformatf("full_count%0d", k), 64'(bus.count), 64'd4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
            chk($sformatf("drain_pc%0d", k), 64'(bus.out_pc), 64'('h200 + 4 * k));
            cyc($sformatf("drain%0d", k));
        end

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, fill_inst[k], XLEN'('h300 + 4 * k), 1'b0, 1'b0);
            cyc($sformatf("pre_flush%0d", k));
        end
        drive(1'b1, 32'h00500093, 'hDEAD0, 1'b1, 1'b1);
        cyc("flush");
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        cyc("post_flush");

        for (int k = 0; k < 2; k++) begin
            drive(1'b1, fill_inst[k], XLEN'('h380 + 4 * k), 1'b0, 1'b0);
            cyc($sformatf("pre_rst%0d", k));
        end
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        #2 nRst = 1'b0;
        q.delete();
        #1 check_all("async_rst");
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        #1 nRst = 1'b1;
        cyc("post_rst");

        drive(1'b1, 32'h00000000, 'h400, 1'b0, 1'b0);
        cyc("zero_inst");
        chk("zero_illegal", 64'(bus.out_illegal), 64'(ILL_EN));
        chk("zero_type", 64'(bus.out_type), 64'd0);
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        cyc("zero_drain");

        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 3) == 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            drive($urandom_range(0, 3) != 0, r, XLEN'($urandom()), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            cyc($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/t03_decode_queue.md
T03_DECODE_QUEUE -- requirements
Module: t03_decode_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32; datapath width of pc and immediate (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4; decoded-entry queue depth (2, 4 or 8).
REQ-003 SHALL have ports clk (in, 1, clock) and nRst (in, 1, reset); one clock, reset asynchronous active-low.
REQ-004 SHALL have flush (in, 1): synchronous queue clear.
REQ-005 SHALL have in_valid (in, 1), in_ready (out, 1), in_inst (in, 32), in_pc (in, XLEN): fetch-side handshake and payload.
REQ-006 SHALL have out_valid (out, 1) and out_ready (in, 1): execute-side handshake.
REQ-007 SHALL have out_pc (out, XLEN), out_rs1, out_rs2, out_rd (out, 5 each), out_type (out, 3), out_control (out, 17), out_imm (out, XLEN), out_illegal (out, 1).
REQ-008 SHALL have count (out, $clog2(DEPTH)+1): number of queued entries.

Function
REQ-009 SHALL decode in_inst combinationally at the input and store the decoded record plus in_pc in the queue on accept (in_valid && in_ready).
REQ-010 SHALL encode out_type as R=0, I=1, S=2, SB=3, UJ=4, U=5.
REQ-011 SHALL map opcodes: 0000011, 0010011, 0011011, 1100111, 1110011, 0001111 -> I; 0110011, 0111011 -> R; 0100011 -> S; 1100011 -> SB; 1101111 -> UJ; 0110111, 0010111 -> U; any other -> R.
REQ-012 SHALL drive fields per type: R all of rs1/rs2/rd/funct3/funct7; I rs1, rd, funct3; S and SB rs1, rs2, funct3; U and UJ rd only; unused fields zero.
REQ-013 SHALL form out_control as {funct7, funct3, opcode}, with zeroed fields per REQ-012.
REQ-014 SHALL sign-extend immediates to XLEN: I inst[31:20]; S {inst[31:25],inst[11:7]}; SB {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; UJ {inst[31],inst[19:12],inst[20],inst[30:21],0}; R zero.
REQ-015 SHALL be a circular FIFO: write and read pointers advance modulo DEPTH; entries leave in acceptance order.
REQ-016 SHALL drive in_ready = (count < DEPTH); when full, no input is accepted even if a pop occurs the same cycle.
REQ-017 SHALL drive out_valid = (count != 0); out_* payload is the head entry; all payload outputs are zero while out_valid = 0.
REQ-018 SHALL pop on out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-019 SHALL give latency of one cycle: an entry accepted at edge N is presented with out_valid = 1 after edge N when the queue was empty; there is no combinational in-to-out bypass.
REQ-020 SHALL, on flush = 1 at an edge, set count and both pointers to 0 and discard any same-cycle push and pop; flush overrides all other events.
REQ-021 SHALL hold out payload stable while out_valid = 1 and out_ready = 0.

Reset
REQ-022 SHALL, while nRst = 0, immediately force count = 0, pointers = 0, out_valid = 0, all payload outputs = 0, in_ready = 1.
REQ-023 SHALL discard all queued entries on reset assertion mid-operation; queue storage need not be cleared.

Configuration
REQ-024 SHALL use macro T03_DECODE_ILLEGAL_EN.
REQ-025 With T03_DECODE_ILLEGAL_EN defined, SHALL set out_illegal = 1 for an entry whose inst[1:0] != 2'b11, whose opcode is outside REQ-011's list, or whose R-type funct7 is neither 0000000 nor 0100000; such entries carry type 0 and all fields zero except out_pc.
REQ-026 Without T03_DECODE_ILLEGAL_EN, SHALL tie out_illegal to 0 and decode unrecognised opcodes as R per REQ-011.

Verification
REQ-027 SHALL cover accept of 0xFFF10093 (addi x1,x2,-1) into an empty queue -> next cycle out_valid=1, type=1, rs1=2, rd=1, rs2=0, imm=all ones, control={0,000,0010011}.
REQ-028 SHALL cover 0xFE208EE3 (beq x1,x2,-4) -> type=3, rs1=1, rs2=2, rd=0, imm=-4 sign-extended to XLEN.
REQ-029 SHALL cover DEPTH=4 with out_ready=0 and 5 back-to-back pushes -> in_ready=0 after the 4th, count=4, 5th held; then out_ready=1 drains 4 entries in push order.
REQ-030 SHALL cover flush=1 with count=3, in_valid=1 and out_ready=1 the same cycle -> next cycle count=0, out_valid=0, in_ready=1; pushed instruction never appears.
REQ-031 SHALL cover nRst pulled low mid-stream with count=2 -> out_valid=0 and count=0 before the next clk edge.
REQ-032 SHALL cover in_inst=0x00000000 -> out_illegal=1 with macro defined; out_illegal=0 and type=0 without it.
